demod_segment_sched: RTL

//  Sequences the unrolled demodulation datapath over one frame of segments.
//  On start, issues NUM segment base words (base + k*STRIDE, k=0..NUM-1) with a

---
 rtl/demod_pkg.sv | 18 +
 rtl/demod_credit_ctr.sv | 40 ++++
 rtl/demod_segment_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/demod_pkg.sv
// Shared definitions for the demodulation segment scheduler.
//   state_t        : scheduler FSM state encoding
//   ST_*           : state constants
//   STRIDE_DEFAULT : default address increment between segments
//   CNT_W          : width of segment / result counters
package demod_pkg;

  localparam int unsigned CNT_W          = 16;
  localparam logic [31:0] STRIDE_DEFAULT = 32'h0001_0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_ERR   = 2'd3;

endpackage

// File: rtl/demod_credit_ctr.sv
// Up/down counter of segments issued to the datapath but not yet returned.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : synchronous clear (takes priority over inc/dec)
//   inc         : one segment issued this cycle
//   dec         : one result returned this cycle (ignored when empty)
//   dec_ok      : dec was accepted (counter was non-zero)
//   count       : current outstanding count
//   count_upd   : count after this cycle's inc/dec, ignoring clr
//   full, empty : count >= MAX, count == 0
module demod_credit_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic         dec_ok,
  output logic [W-1:0] count,
  output logic [W-1:0] count_upd,
  output logic         full,
  output logic         empty
);

  assign empty     = (count == '0);
  assign full      = (count >= W'(MAX));
  assign dec_ok    = dec && !empty;
  assign count_upd = count + W'(inc) - W'(dec_ok);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else begin
      count <= count_upd;
    end
  end

endmodule

// File: rtl/demod_segment_sched.sv
// Sequences the demodulation datapath over one frame of segments: issues
// base + k*STRIDE words with a valid/ready handshake, bounds in-flight work,
// counts returned results, and reports done or a timeout error.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start, abort  : frame start (IDLE only) / return to IDLE
//   base_addr     : first segment word, sampled on accepted start
//   num_segments  : segments in frame, sampled on accepted start (0 = empty)
//   seg_valid/seg_ready, segment_0, seg_index : issue handshake and payload
//   res_valid     : one pulse per completed segment
//   busy          : high in RUN
//   done          : one-cycle pulse at normal completion
//   err_timeout   : sticky timeout flag, cleared by accepted start
//   res_count     : results received this frame
module demod_segment_sched
  import demod_pkg::*;
#(
  parameter logic [31:0] STRIDE    = STRIDE_DEFAULT,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_segments,
  output logic             seg_valid,
  input  logic             seg_ready,
  output logic [31:0]      segment_0,
  output logic [CNT_W-1:0] seg_index,
  input  logic             res_valid,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] res_count
);

  localparam int unsigned     OUT_W    = 4;
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   num_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   tmo_d;
  logic [CNT_W-1:0]   res_count_upd;
  logic [OUT_W-1:0]   outst;
  logic [OUT_W-1:0]   outst_upd;
  logic               outst_full;
  logic               outst_empty;
  logic               res_ok;
  logic               accept;
  logic               tmo_hit;
  logic               clr_cnt;
  logic               start_ok;
  logic               set_err;
  logic               done_d;

  demod_credit_ctr #(
    .MAX (MAX_OUTST),
    .W   (OUT_W)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_cnt),
    .inc       (accept),
    .dec       (res_valid && (state_q != ST_IDLE)),
    .dec_ok    (res_ok),
    .count     (outst),
    .count_upd (outst_upd),
    .full      (outst_full),
    .empty     (outst_empty)
  );

  // seg_index doubles as the issued count; it only moves on accept, so a raised
  // seg_valid cannot drop in RUN until the word is taken.
  assign seg_valid     = (state_q == ST_RUN) && (seg_index != num_q) && !outst_full;
  assign accept        = seg_valid && seg_ready;
  assign busy          = (state_q == ST_RUN);
  assign res_count_upd = res_count + CNT_W'(res_ok);

  // Timer only runs while work is in flight and no result has arrived.
  assign tmo_hit = (state_q == ST_RUN) && !res_valid && !outst_empty && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = '0;
    if ((state_q == ST_RUN) && !res_valid && !outst_empty) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    clr_cnt  = 1'b0;
    start_ok = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          clr_cnt = 1'b1;
        end else if (start) begin
          if (num_segments == '0) begin
            done_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            clr_cnt  = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Anything accepted this cycle still has to drain.
          if (outst_upd == '0) begin
            clr_cnt = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if ((seg_index == num_q) && (res_count_upd == num_q)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_FLUSH, ST_ERR: begin
        if (abort || (outst_upd == '0)) begin
          clr_cnt = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        clr_cnt = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      segment_0   <= '0;
      seg_index   <= '0;
      res_count   <= '0;
      tmo_q       <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      tmo_q   <= tmo_d;

      if (start_ok) begin
        segment_0 <= base_addr;
        num_q     <= num_segments;
      end else if (accept) begin
        segment_0 <= segment_0 + STRIDE;
      end

      if (clr_cnt) begin
        seg_index <= '0;
        res_count <= '0;
      end else begin
        if (accept) begin
          seg_index <= seg_index + CNT_W'(1);
        end
        res_count <= res_count_upd;
      end

      if (start_ok) begin
        err_timeout <= 1'b0;
      end else if (set_err) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule
